// File: rtl/analog_mux_sequencer_pkg.sv
// Shared types and width helpers for the analog mux sequencer.
package analog_mux_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_MAKE  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Timer must hold either a full dwell or the dead-time count.
  function automatic int timer_w(input int dwell_w, input int dead_cyc);
    int dc_w;
    dc_w = $clog2(dead_cyc + 1);
    return (dwell_w > dc_w) ? dwell_w : dc_w;
  endfunction

endpackage

// File: rtl/analog_mux_sequencer_if.sv
// Channel-request handshake between a requester (master) and the sequencer (slave).
interface analog_mux_sequencer_if #(
  parameter int CH_W    = 2,
  parameter int DWELL_W = 8
);
  logic               req_valid;
  logic               req_ready;
  logic [CH_W-1:0]    req_ch;
  logic [DWELL_W-1:0] dwell;

  modport master (output req_valid, req_ch, dwell, input req_ready);
  modport slave  (input req_valid, req_ch, dwell, output req_ready);
endinterface

// File: rtl/analog_mux_sequencer_timer.sv
// Loadable down-counter shared by the dead-time, settle and dwell phases.
module mux_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         expire
);
  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expire = (count_q == W'(1));
endmodule

// File: rtl/analog_mux_sequencer.sv
// Break-before-make sequencer driving analog mux ctrl lines from channel requests.
// Optional auto-scan is built when MUX_SEQ_AUTOSCAN_EN is defined.
// state | meaning
// IDLE  | all muxes open, waiting for a request
// BREAK | all muxes open, dead time before closing the new channel
// MAKE  | selected mux closed, settle time running
// HOLD  | settled; dwell running (dwell 0 holds until retarget)
module analog_mux_sequencer
  import analog_mux_sequencer_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DEAD_CYC = 4,
  parameter int DWELL_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  analog_mux_sequencer_if.slave req,
  input  logic                  scan_en,
  output logic [N_CH-1:0]       mux_ctrl,
  output logic                  settled,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int               CH_W    = ch_w(N_CH);
  localparam int               TMR_W   = timer_w(DWELL_W, DEAD_CYC);
  localparam logic [CH_W:0]    N_CH_L  = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);
  localparam logic [TMR_W-1:0] DEAD_L  = TMR_W'(DEAD_CYC);

  seq_state_e         state_q, state_nxt;
  logic [CH_W-1:0]    ch_q, ch_nxt, ch_scan;
  logic [DWELL_W-1:0] dwell_q, dwell_nxt;
  logic [TMR_W-1:0]   tmr_value;
  logic               tmr_load, tmr_dec, tmr_expire;
  logic               accept, ch_ok, scan_go;

  assign req.req_ready = ena && !rst && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
  assign accept  = req.req_valid && req.req_ready;
  assign ch_ok   = ({1'b0, req.req_ch} < N_CH_L);
  assign err     = accept && !ch_ok;
  assign ch_scan = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
  assign settled = (state_q == ST_HOLD);
  assign busy    = (state_q != ST_IDLE);

`ifdef MUX_SEQ_AUTOSCAN_EN
  assign scan_go = scan_en && ena;
`else
  logic unused_scan;
  assign unused_scan = scan_en;
  assign scan_go     = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    ch_nxt    = ch_q;
    dwell_nxt = dwell_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_value = DEAD_L;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && ch_ok) begin
          ch_nxt    = req.req_ch;
          dwell_nxt = req.dwell;
          tmr_load  = 1'b1;
          state_nxt = ST_BREAK;
        end else if (scan_go && !accept) begin
          ch_nxt    = ch_scan;
          dwell_nxt = req.dwell;
          tmr_load  = 1'b1;
          state_nxt = ST_BREAK;
        end
      end
      ST_BREAK: begin
        tmr_dec = 1'b1;
        if (tmr_expire) begin
          tmr_load  = 1'b1;
          state_nxt = ST_MAKE;
        end
      end
      ST_MAKE: begin
        tmr_dec = 1'b1;
        if (tmr_expire) begin
          tmr_load  = 1'b1;
          tmr_value = TMR_W'(dwell_q);
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // An accepted request pre-empts dwell expiry in the same cycle.
        if (accept) begin
          if (ch_ok) begin
            ch_nxt    = req.req_ch;
            dwell_nxt = req.dwell;
            tmr_load  = 1'b1;
            state_nxt = ST_BREAK;
          end
        end else if (dwell_q != '0) begin
          tmr_dec = 1'b1;
          if (tmr_expire) begin
            done = 1'b1;
            if (scan_go) begin
              ch_nxt    = ch_scan;
              dwell_nxt = req.dwell;
              tmr_load  = 1'b1;
              state_nxt = ST_BREAK;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rst || !ena) begin
      state_nxt = ST_IDLE;
      ch_nxt    = ch_q;
      dwell_nxt = dwell_q;
      tmr_load  = 1'b0;
      tmr_dec   = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      dwell_q  <= '0;
      mux_ctrl <= '0;
    end else begin
      state_q  <= state_nxt;
      ch_q     <= ch_nxt;
      dwell_q  <= dwell_nxt;
      // Driven from the next state so opening is never a cycle late.
      mux_ctrl <= ((state_nxt == ST_MAKE) || (state_nxt == ST_HOLD)) ?
                  (N_CH'(1) << ch_nxt) : '0;
    end
  end

  mux_seq_timer #(.W(TMR_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .dec    (tmr_dec),
    .value  (tmr_value),
    .expire (tmr_expire)
  );
endmodule

// File: tb/tb_analog_mux_sequencer.sv
// Directed scoreboard bench for analog_mux_sequencer (N_CH=4) plus an N_CH=5 instance
// for out-of-range channel requests. Auto-scan steps run when MUX_SEQ_AUTOSCAN_EN is defined.
`timescale 1ns/1ps
module tb_analog_mux_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic scan_en = 1'b0;
  always #5 clk = ~clk;

  analog_mux_sequencer_if #(.CH_W(2), .DWELL_W(8)) rq   ();
  analog_mux_sequencer_if #(.CH_W(3), .DWELL_W(8)) rq_e ();

  logic [3:0] mux_ctrl;
  logic       settled, busy, done, err;
  logic [4:0] mux_ctrl_e;
  logic       settled_e, busy_e, done_e, err_e;

  analog_mux_sequencer #(.N_CH(4), .DEAD_CYC(4), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(rq), .scan_en(scan_en),
    .mux_ctrl(mux_ctrl), .settled(settled), .busy(busy), .done(done), .err(err)
  );

  analog_mux_sequencer #(.N_CH(5), .DEAD_CYC(4), .DWELL_W(8)) dut_e (
    .clk(clk), .rst(rst), .ena(ena), .req(rq_e), .scan_en(1'b0),
    .mux_ctrl(mux_ctrl_e), .settled(settled_e), .busy(busy_e), .done(done_e), .err(err_e)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] mux;
    logic       settled;
    logic       busy;
    logic       done;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [3:0] mux, input logic s, input logic b,
                        input logic done_last);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.mux     = mux;
      e.settled = s;
      e.busy    = b;
      e.done    = done_last && (i == n - 1);
      sb.push_back(e);
    end
  endtask

  // Timeline after an accept: DEAD_CYC open, DEAD_CYC closed unsettled, then dwell.
  task automatic push_seq(input int ch, input int dw);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    push_n(4, 4'b0000, 1'b0, 1'b1, 1'b0);
    push_n(4, oh, 1'b0, 1'b1, 1'b0);
    if (dw > 0) begin
      push_n(dw, oh, 1'b1, 1'b1, 1'b1);
      push_n(1, 4'b0000, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".mux"},     32'(mux_ctrl), 32'(e.mux));
      check({tag, ".settled"}, 32'(settled),  32'(e.settled));
      check({tag, ".busy"},    32'(busy),     32'(e.busy));
      check({tag, ".done"},    32'(done),     32'(e.done));
      check({tag, ".err"},     32'(err),      32'd0);
      tick();
    end
  endtask

  task automatic request(input logic [1:0] ch, input logic [7:0] dw);
    rq.req_valid = 1'b1;
    rq.req_ch    = ch;
    rq.dwell     = dw;
    #1;
    check("req_ready_at_accept", 32'(rq.req_ready), 32'd1);
    tick();
    rq.req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) check("onehot", 32'($countones(mux_ctrl) <= 1), 32'd1);
  end

  initial begin
    rq.req_valid   = 1'b0;
    rq.req_ch      = '0;
    rq.dwell       = '0;
    rq_e.req_valid = 1'b0;
    rq_e.req_ch    = '0;
    rq_e.dwell     = '0;

    // Reset
    tick();
    tick();
    check("rst.mux",     32'(mux_ctrl),     32'd0);
    check("rst.settled", 32'(settled),      32'd0);
    check("rst.busy",    32'(busy),         32'd0);
    check("rst.done",    32'(done),         32'd0);
    check("rst.err",     32'(err),          32'd0);
    check("rst.ready",   32'(rq.req_ready), 32'd0);
    check("rst.mux_e",   32'(mux_ctrl_e),   32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(rq.req_ready), 32'd1);

    // Full sequence ch2, dwell 10
    request(2'd2, 8'd10);
    push_seq(2, 10);
    drain("seq_ch2");

    // Retarget ch1 -> ch3 with indefinite dwell
    request(2'd1, 8'd0);
    push_seq(1, 0);
    push_n(3, 4'b0010, 1'b1, 1'b1, 1'b0);
    drain("hold_ch1");
    request(2'd3, 8'd0);
    push_seq(3, 0);
    push_n(2, 4'b1000, 1'b1, 1'b1, 1'b0);
    drain("retarget_ch3");
    ena = 1'b0;
    tick();
    check("ena_off_hold.mux", 32'(mux_ctrl), 32'd0);
    ena = 1'b1;
    tick();

    // Request collides with dwell expiry: request wins, no done
    request(2'd0, 8'd1);
    push_seq(0, 0);
    drain("collide_pre");
    check("collide.done_alone", 32'(done), 32'd1);
    rq.req_valid = 1'b1;
    rq.req_ch    = 2'd2;
    rq.dwell     = 8'd0;
    #1;
    check("collide.done_suppressed", 32'(done), 32'd0);
    tick();
    rq.req_valid = 1'b0;
    push_seq(2, 0);
    push_n(1, 4'b0100, 1'b1, 1'b1, 1'b0);
    drain("collide_post");
    ena = 1'b0;
    tick();
    ena = 1'b1;
    tick();

    // Out-of-range channel on the N_CH=5 instance, from IDLE then from HOLD
    rq_e.req_valid = 1'b1;
    rq_e.req_ch    = 3'd5;
    #1;
    check("err_idle.pulse", 32'(err_e), 32'd1);
    tick();
    rq_e.req_valid = 1'b0;
    #1;
    check("err_idle.cleared", 32'(err_e),      32'd0);
    check("err_idle.busy",    32'(busy_e),     32'd0);
    check("err_idle.mux",     32'(mux_ctrl_e), 32'd0);
    rq_e.req_valid = 1'b1;
    rq_e.req_ch    = 3'd4;
    tick();
    rq_e.req_valid = 1'b0;
    repeat (8) tick();
    check("err_hold.pre_mux",     32'(mux_ctrl_e), 32'h10);
    check("err_hold.pre_settled", 32'(settled_e),  32'd1);
    rq_e.req_valid = 1'b1;
    rq_e.req_ch    = 3'd6;
    #1;
    check("err_hold.pulse", 32'(err_e), 32'd1);
    tick();
    rq_e.req_valid = 1'b0;
    #1;
    check("err_hold.cleared", 32'(err_e),      32'd0);
    check("err_hold.mux",     32'(mux_ctrl_e), 32'h10);
    check("err_hold.settled", 32'(settled_e),  32'd1);
    check("err_hold.busy",    32'(busy_e),     32'd1);

    // ena dropped in MAKE
    request(2'd1, 8'd5);
    repeat (5) tick();
    check("ena_make.pre_mux", 32'(mux_ctrl), 32'b0010);
    ena = 1'b0;
    tick();
    check("ena_make.mux",     32'(mux_ctrl),     32'd0);
    check("ena_make.busy",    32'(busy),         32'd0);
    check("ena_make.done",    32'(done),         32'd0);
    check("ena_make.settled", 32'(settled),      32'd0);
    check("ena_make.ready",   32'(rq.req_ready), 32'd0);
    ena = 1'b1;
    tick();

    // ena dropped in the cycle the dwell would expire
    request(2'd2, 8'd3);
    repeat (10) tick();
    check("ena_expiry.pre_done", 32'(done), 32'd1);
    ena = 1'b0;
    #1;
    check("ena_expiry.done", 32'(done), 32'd0);
    tick();
    check("ena_expiry.mux",  32'(mux_ctrl), 32'd0);
    check("ena_expiry.busy", 32'(busy),     32'd0);
    ena = 1'b1;
    tick();

    // rst asserted in HOLD
    request(2'd3, 8'd0);
    repeat (9) tick();
    check("rst_hold.pre_settled", 32'(settled),  32'd1);
    check("rst_hold.pre_mux",     32'(mux_ctrl), 32'b1000);
    rst = 1'b1;
    tick();
    check("rst_hold.mux",     32'(mux_ctrl), 32'd0);
    check("rst_hold.busy",    32'(busy),     32'd0);
    check("rst_hold.done",    32'(done),     32'd0);
    check("rst_hold.settled", 32'(settled),  32'd0);
    rst = 1'b0;
    tick();

`ifdef MUX_SEQ_AUTOSCAN_EN
    // Auto-scan from cleared channel 0: visits 1, 2, 3, 0, 1
    rq.dwell = 8'd3;
    scan_en  = 1'b1;
    tick();
    begin
      int order[5];
      order = '{1, 2, 3, 0, 1};
      for (int i = 0; i < 5; i++) begin
        push_n(4, 4'b0000, 1'b0, 1'b1, 1'b0);
        push_n(4, 4'b0001 << order[i], 1'b0, 1'b1, 1'b0);
        push_n(3, 4'b0001 << order[i], 1'b1, 1'b1, 1'b1);
      end
    end
    drain("scan");
    scan_en = 1'b0;
    ena     = 1'b0;
    tick();
    ena = 1'b1;
    tick();
`else
    scan_en = 1'b1;
    repeat (3) tick();
    check("scan_ignored.busy", 32'(busy),     32'd0);
    check("scan_ignored.mux",  32'(mux_ctrl), 32'd0);
    scan_en = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
